// File: rtl/sm_result_collector.sv
// sm_result_collector: buffers stack machine result/error reports in a FIFO,
// drains them on a valid/ready stream and tracks per-category counts and completion.
module sm_result_collector #(
  parameter int DEPTH = 8,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [DW-1:0] out_data,
  input  logic [2:0]    err_code,
  input  logic          fin,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW+2:0] m_data,
  output logic [9:0]    cnt_ok,
  output logic [9:0]    cnt_stk,
  output logic [9:0]    cnt_und,
  output logic          overflow,
  output logic          done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic [9:0]    ok_q, ok_d, stk_q, stk_d, und_q, und_d;
  logic          ovf_q, ovf_d;
  logic          cap, pop, push, is_ok, is_stk, is_und;
  logic [DW+2:0] mem_q [DEPTH];
  always_comb begin
    cap     = d_valid && state_q == RUN;
    pop     = m_valid && m_ready;
    push    = cap && (occ_q != (AW+1)'(DEPTH) || pop);
    is_ok   = err_code == 3'b000;
    is_stk  = err_code[2] || err_code[0];
    is_und  = !is_ok && !is_stk;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    occ_d   = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    ok_d    = ok_q  + 10'(cap && is_ok  && ok_q  != 10'h3ff);
    stk_d   = stk_q + 10'(cap && is_stk && stk_q != 10'h3ff);
    und_d   = und_q + 10'(cap && is_und && und_q != 10'h3ff);
    ovf_d   = ovf_q || (cap && !push);
    state_d = (state_q == RUN && fin) ? DRAIN :
              (state_q == DRAIN && occ_q == '0) ? DONE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      ok_q    <= '0;
      stk_q   <= '0;
      und_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      ok_q    <= ok_d;
      stk_q   <= stk_d;
      und_q   <= und_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage needs no reset: m_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {err_code, out_data};
  end
  assign m_valid  = occ_q != '0;
  assign m_data   = m_valid ? mem_q[rd_q] : '0;
  assign cnt_ok   = ok_q;
  assign cnt_stk  = stk_q;
  assign cnt_und  = und_q;
  assign overflow = ovf_q;
  assign done     = state_q == DONE;
endmodule

// File: doc/sm_result_collector.md
# sm_result_collector

Downstream stage of the stack machine: samples every result/error report the machine emits (d_valid with out_data and err_code), buffers it in a small FIFO, and drains it to a consumer through a valid/ready stream. It also keeps per-category result counters, a sticky overflow flag, and a done indication once the machine signals fin and the FIFO has drained.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- DW, 20: data width of out_data.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- d_valid  in  1  stack machine result/error strobe, one cycle per report.
- out_data  in  DW  stack machine result value (two's complement).
- err_code  in  3  000 ok, 001 stack error, 010 undefined opcode, 100 invalid operand.
- fin  in  1  stack machine program-finished level.
- m_valid  out  1  entry available on m_data.
- m_ready  in  1  consumer accepts entry.
- m_data  out  DW+3  {err_code, out_data} of the head entry.
- cnt_ok  out  10  reports with err_code==000.
- cnt_stk  out  10  reports with err_code[2] or err_code[0] set.
- cnt_und  out  10  other nonzero err_code reports.
- overflow  out  1  sticky: a report was dropped because the FIFO was full.
- done  out  1  sticky: fin seen and FIFO empty.

## Operation
- States: RUN (after reset), DRAIN, DONE.
- RUN: each cycle with d_valid=1 is a capture event. fin=1 → DRAIN next cycle; a d_valid in the same cycle as the first fin is still captured.
- DRAIN: d_valid is ignored (no push, no counting). FIFO empty → DONE next cycle; if already empty on entry, DONE one cycle after entering DRAIN.
- DONE: done=1, no captures, stream still serviceable (FIFO is empty). Only reset leaves DONE.
- Capture event: classify err_code and increment exactly one counter; counters saturate at 1023 and do not wrap. Counting happens even if the entry is dropped.
- Push: {err_code, out_data} written at the tail if the FIFO is not full, or if it is full and a pop happens in the same cycle (the freed slot is reused). Otherwise the entry is dropped and overflow is set.
- Pop: m_valid & m_ready at a rising edge. Head advances, pointers wrap modulo DEPTH.
- Occupancy counter is 0..DEPTH. Simultaneous push and pop leaves occupancy unchanged.
- m_valid = occupancy != 0. m_data is the registered head entry and stays stable while m_valid=1 and m_ready=0.
- No combinational path from d_valid/out_data to m_valid/m_data (no empty bypass).

## Timing
- Reset (asynchronous assert, deassert synchronous to clk): state RUN, pointers and occupancy 0, m_valid=0, m_data=0, counters 0, overflow=0, done=0.
- Reset mid-stream discards all FIFO contents and counters immediately.
- Capture-to-output latency: d_valid at edge N → m_valid=1 after edge N (available from cycle N+1) when the FIFO was empty.
- Counters update at the same edge as the capture.
- Throughput: one push and one pop per cycle sustained.
- overflow sets at the edge of the dropped capture.
- fin sampled at edge N in RUN → DRAIN after N. FIFO empty in DRAIN at edge M → done=1 after M.
- m_ready is ignored when m_valid=0 (no underflow, no pointer motion).

## Test plan
- Basic: reset, then d_valid with out_data=0x00005/err 000, then 0xFFFFD/err 000, m_ready=1 → m_data 0x000005 then 0x0FFFFD on consecutive cycles, cnt_ok=2.
- Errors: one report each of err_code 001, 010, and 100 → cnt_stk=2, cnt_und=1, cnt_ok=0; m_data[22:20] matches in order.
- Overflow: m_ready=0, 9 back-to-back d_valid with values 1..9 → entries 1..8 held, overflow=1, cnt_ok=9; then drain → 1..8 in order, m_valid=0.
- Full plus simultaneous pop: FIFO full, m_ready=1 and d_valid (value 0x12345) in the same cycle → no overflow, occupancy stays 8, 0x12345 is the last entry out.
- Finish: 3 entries queued, fin=1 with m_ready=0 → DRAIN, extra d_valid ignored (counters unchanged); raise m_ready → 3 pops, done=1 the cycle after empty.
- Reset mid-drain: 4 entries queued, pulse rst_n low asynchronously between edges → m_valid=0, counters 0, overflow=0, done=0 immediately.
